// File: rtl/inst_issuer.sv
// Instruction issuer: queues load/nop requests and drives
// the register-bank peripheral's instruction bus with a gap.
module inst_issuer #(
  parameter int unsigned GAP = 0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [1:0]  req_op,
  input  logic [7:0]  req_imm,
  input  logic        req_valid,
  output logic        req_ready,
  output logic [11:0] inst,
  output logic        inst_en,
  output logic [7:0]  shadow_0,
  output logic [7:0]  shadow_1,
  output logic        busy,
  output logic        error
);

  localparam logic [3:0] GAP_L = 4'(GAP);

  typedef enum logic [1:0] {
    ST_RESET,
    ST_READY,
    ST_ERROR
  } state_t;

  state_t      state;
  state_t      state_nx;
  logic [9:0]  fifo [4];
  logic [1:0]  wr_ptr;
  logic [1:0]  rd_ptr;
  logic [2:0]  count;
  logic [3:0]  gap_cnt;
  logic        accept;
  logic        illegal;
  logic        push;
  logic        pop;
  logic [9:0]  head;
  logic [3:0]  code;
  logic [7:0]  head_imm;

  // handshake and issue decisions from registered state
  always_comb begin
    req_ready = (state == ST_READY) && (count < 3'd4);
    accept    = req_valid && req_ready;
    illegal   = accept && (req_op == 2'd3);
    push      = accept && !illegal;
    pop       = (state == ST_READY) && (count != 3'd0)
             && (gap_cnt == 4'd0) && !illegal;
    head      = fifo[rd_ptr];
    busy      = (count != 3'd0) || (gap_cnt != 4'd0);
    error     = (state == ST_ERROR);
  end

  // opcode to instruction code; nop carries a zero immediate
  always_comb begin
    code     = 4'h0;
    head_imm = 8'h00;
    unique case (1'b1)
      head[9:8] == 2'd1: begin
        code     = 4'h1;
        head_imm = head[7:0];
      end
      head[9:8] == 2'd2: begin
        code     = 4'h2;
        head_imm = head[7:0];
      end
      default: begin
        code     = 4'h0;
        head_imm = 8'h00;
      end
    endcase
  end

  // next state: one reset cycle, then ready until an illegal op
  always_comb begin
    state_nx = state;
    unique case (state)
      ST_RESET: state_nx = ST_READY;
      ST_READY: if (illegal) state_nx = ST_ERROR;
      ST_ERROR: state_nx = ST_ERROR;
      default:  state_nx = ST_RESET;
    endcase
  end

  // state register
  always_ff @(posedge clock) begin
    if (reset) state <= ST_RESET;
    else       state <= state_nx;
  end

  // fifo storage, written at the tail on accepted legal requests
  always_ff @(posedge clock) begin
    if (push) fifo[wr_ptr] <= {req_op, req_imm};
  end

  // fifo pointers and occupancy; an illegal op flushes the queue
  always_ff @(posedge clock) begin
    if (reset || illegal) begin
      wr_ptr <= 2'd0;
      rd_ptr <= 2'd0;
      count  <= 3'd0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 2'd1;
      if (pop)  rd_ptr <= rd_ptr + 2'd1;
      unique case ({push, pop})
        2'b10:   count <= count + 3'd1;
        2'b01:   count <= count - 3'd1;
        default: count <= count;
      endcase
    end
  end

  // gap counter reloads on issue and drains one per cycle
  always_ff @(posedge clock) begin
    if (reset || illegal)      gap_cnt <= 4'd0;
    else if (pop)              gap_cnt <= GAP_L;
    else if (gap_cnt != 4'd0)  gap_cnt <= gap_cnt - 4'd1;
  end

  // instruction bus and shadows; zeroed while in error
  always_ff @(posedge clock) begin
    if (reset || illegal || state == ST_ERROR) begin
      inst     <= 12'h000;
      inst_en  <= 1'b0;
      shadow_0 <= 8'h00;
      shadow_1 <= 8'h00;
    end else begin
      inst_en <= pop;
      if (pop) begin
        inst <= {code, head_imm};
        if (code == 4'h1) shadow_0 <= head_imm;
        if (code == 4'h2) shadow_1 <= head_imm;
      end
    end
  end

endmodule
